// File: rtl/max7219_receiver.sv
// ============================================================================
// max7219_receiver : 3-wire serial receive end with MAX7219-style registers
// Revision 1.0
// ============================================================================
`default_nettype none

module max7219_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int ROWS        = 8
) (
  input  logic        clk_in,
  input  logic        reset_n_in,
  input  logic        ser_clk_in,
  input  logic        ser_data_in,
  input  logic        ser_latch_in,
  input  logic [2:0]  row_addr_in,
  output logic [7:0]  row_data_out,
  output logic [7:0]  decode_mode_out,
  output logic [3:0]  intensity_out,
  output logic [2:0]  scan_limit_out,
  output logic        shutdown_n_out,
  output logic        display_test_out,
  output logic        word_valid_out,
  output logic [15:0] word_out,
  output logic        short_frame_out,
  output logic        dout_out
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  logic [1:0]             rst_sync_q;
  logic                   rst_n_w;
  logic [SYNC_STAGES:0]   sclk_q;
  logic [SYNC_STAGES:0]   slat_q;
  logic [SYNC_STAGES-1:0] sdat_q;
  logic                   clk_rise_w;
  logic                   lat_rise_w;
  logic                   data_w;

  logic [1:0]  state_q, state_d;
  logic [15:0] shift_q, shift_d;
  logic [4:0]  count_q, count_d;
  logic        commit_w;
  logic [3:0]  addr_w;

  logic [7:0]  ram_q [ROWS];
  logic [7:0]  row_data_q;
  logic [7:0]  decode_q;
  logic [3:0]  intensity_q;
  logic [2:0]  scan_q;
  logic        shutdown_n_q;
  logic        test_q;
  logic        valid_q;
  logic [15:0] word_q;
  logic        short_q;

  // Reset asserts asynchronously but is released on a clk_in edge.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) rst_sync_q <= 2'b00;
    else             rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n_w = rst_sync_q[1];

  always_ff @(posedge clk_in or negedge rst_n_w) begin
    if (!rst_n_w) begin
      sclk_q <= '0;
      slat_q <= '0;
      sdat_q <= '0;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-1:0], ser_clk_in};
      slat_q <= {slat_q[SYNC_STAGES-1:0], ser_latch_in};
      sdat_q <= {sdat_q[SYNC_STAGES-2:0], ser_data_in};
    end
  end

  assign clk_rise_w = sclk_q[SYNC_STAGES-1] & ~sclk_q[SYNC_STAGES];
  assign lat_rise_w = slat_q[SYNC_STAGES-1] & ~slat_q[SYNC_STAGES];
  assign data_w     = sdat_q[SYNC_STAGES-1];
  assign commit_w   = (state_q == ST_COMMIT);
  assign addr_w     = shift_q[11:8];

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE, ST_SHIFT: begin
        if (clk_rise_w) begin
          shift_d = {shift_q[14:0], data_w};
          count_d = (count_q == 5'd31) ? 5'd31 : count_q + 5'd1;
          state_d = ST_SHIFT;
        end
        // Shift happens first, so a same-cycle latch commits the new bit.
        if (lat_rise_w && (count_d != 5'd0)) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        count_d = 5'd0;
        state_d = ST_IDLE;
        if (clk_rise_w) begin
          shift_d = {shift_q[14:0], data_w};
          count_d = 5'd1;
          state_d = ST_SHIFT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_w) begin
    if (!rst_n_w) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_w) begin
    if (!rst_n_w) begin
      decode_q     <= '0;
      intensity_q  <= '0;
      scan_q       <= '0;
      shutdown_n_q <= 1'b0;
      test_q       <= 1'b0;
      valid_q      <= 1'b0;
      word_q       <= '0;
      short_q      <= 1'b0;
    end else begin
      valid_q <= commit_w;
      short_q <= commit_w && (count_q < 5'd16);
      if (commit_w) begin
        word_q <= shift_q;
        case (addr_w)
          4'h9: decode_q     <= shift_q[7:0];
          4'hA: intensity_q  <= shift_q[3:0];
          4'hB: scan_q       <= shift_q[2:0];
          4'hC: shutdown_n_q <= shift_q[0];
          4'hF: test_q       <= shift_q[0];
          default: ;
        endcase
      end
    end
  end

  // Row RAM: read returns the pre-write contents on a same-cycle collision.
  always_ff @(posedge clk_in or negedge rst_n_w) begin
    if (!rst_n_w) begin
      for (int r = 0; r < ROWS; r++) ram_q[r] <= '0;
      row_data_q <= '0;
    end else begin
      for (int r = 0; r < ROWS; r++) begin
        if (commit_w && (addr_w == 4'(r + 1))) ram_q[r] <= shift_q[7:0];
      end
      row_data_q <= ({29'd0, row_addr_in} < ROWS) ? ram_q[row_addr_in] : 8'd0;
    end
  end

  assign row_data_out     = row_data_q;
  assign decode_mode_out  = decode_q;
  assign intensity_out    = intensity_q;
  assign scan_limit_out   = scan_q;
  assign shutdown_n_out   = shutdown_n_q;
  assign display_test_out = test_q;
  assign word_valid_out   = valid_q;
  assign word_out         = word_q;
  assign short_frame_out  = short_q;
  assign dout_out         = shift_q[15];

endmodule

`default_nettype wire

// File: tb/tb_max7219_receiver.sv
// ============================================================================
// tb_max7219_receiver : directed + random bench with a bit-history model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_max7219_receiver;

  localparam int PH = 6;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ser_clk = 1'b0;
  logic        ser_data = 1'b0;
  logic        ser_latch = 1'b0;
  logic [2:0]  row_addr = 3'd0;
  logic [7:0]  row_data;
  logic [7:0]  decode_mode;
  logic [3:0]  intensity;
  logic [2:0]  scan_limit;
  logic        shutdown_n;
  logic        display_test;
  logic        word_valid;
  logic [15:0] word;
  logic        short_frame;
  logic        dout;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: every bit received since reset; the committed word is the last 16.
  logic       hist[$];
  int         m_cnt = 0;
  logic [7:0] m_rows[8];
  logic [7:0] m_dec;
  logic [3:0] m_int;
  logic [2:0] m_scan;
  logic       m_sd, m_test;
  logic [15:0] m_word;
  logic       m_pulse, m_short;

  always #5 clk = ~clk;

  max7219_receiver dut (
    .clk_in          (clk),
    .reset_n_in      (reset_n),
    .ser_clk_in      (ser_clk),
    .ser_data_in     (ser_data),
    .ser_latch_in    (ser_latch),
    .row_addr_in     (row_addr),
    .row_data_out    (row_data),
    .decode_mode_out (decode_mode),
    .intensity_out   (intensity),
    .scan_limit_out  (scan_limit),
    .shutdown_n_out  (shutdown_n),
    .display_test_out(display_test),
    .word_valid_out  (word_valid),
    .word_out        (word),
    .short_frame_out (short_frame),
    .dout_out        (dout)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_cnt = 0;
    for (int r = 0; r < 8; r++) m_rows[r] = 8'h00;
    m_dec = 0; m_int = 0; m_scan = 0; m_sd = 0; m_test = 0; m_word = 0;
  endtask

  function automatic logic [15:0] last16();
    logic [15:0] w;
    int idx;
    w = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      idx = hist.size() - 16 + i;
      w[15 - i] = (idx >= 0) ? hist[idx] : 1'b0;
    end
    return w;
  endfunction

  task automatic model_commit();
    int a;
    m_pulse = (m_cnt > 0);
    m_short = (m_cnt > 0) && (m_cnt < 16);
    if (m_cnt > 0) begin
      m_word = last16();
      a = int'(m_word[11:8]);
      if (a >= 1 && a <= 8) m_rows[a - 1] = m_word[7:0];
      else if (a == 9)  m_dec  = m_word[7:0];
      else if (a == 10) m_int  = m_word[3:0];
      else if (a == 11) m_scan = m_word[2:0];
      else if (a == 12) m_sd   = m_word[0];
      else if (a == 15) m_test = m_word[0];
      m_cnt = 0;
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk) ser_data = b;
    repeat (PH) @(negedge clk);
    ser_clk = 1'b1;
    hist.push_back(b);
    m_cnt++;
    repeat (PH) @(negedge clk);
    ser_clk = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic check_state(input string tag);
    logic exp_dout;
    exp_dout = (hist.size() >= 16) ? hist[hist.size() - 16] : 1'b0;
    chk({tag, "_dout"}, 16'(dout), 16'(exp_dout));
    chk({tag, "_decode"}, 16'(decode_mode), 16'(m_dec));
    chk({tag, "_intensity"}, 16'(intensity), 16'(m_int));
    chk({tag, "_scan"}, 16'(scan_limit), 16'(m_scan));
    chk({tag, "_shutdn"}, 16'(shutdown_n), 16'(m_sd));
    chk({tag, "_test"}, 16'(display_test), 16'(m_test));
    for (int r = 0; r < 8; r++) begin
      @(negedge clk) row_addr = 3'(r);
      @(negedge clk);
      chk($sformatf("%s_row%0d", tag, r), 16'(row_data), 16'(m_rows[r]));
    end
  endtask

  task automatic commit_check(input string tag);
    logic seen;
    model_commit();
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      if (word_valid) seen = 1'b1;
    end
    chk({tag, "_valid"}, 16'(seen), 16'(m_pulse));
    if (seen) begin
      chk({tag, "_word"}, word, m_word);
      chk({tag, "_short"}, 16'(short_frame), 16'(m_short));
      @(negedge clk);
      chk({tag, "_pulse_end"}, 16'(word_valid), 16'h0);
    end
  endtask

  task automatic latch_word(input string tag);
    @(negedge clk) ser_latch = 1'b1;
    commit_check(tag);
    repeat (2) @(negedge clk);
    ser_latch = 1'b0;
    repeat (PH) @(negedge clk);
    check_state(tag);
  endtask

  task automatic send_word(input logic [15:0] w, input string tag);
    send_bits(32'(w), 16);
    latch_word(tag);
  endtask

  initial begin
    logic [15:0] rows_in[8];
    rows_in = '{16'h013C, 16'h027E, 16'h0399, 16'h04FF,
                16'h05FF, 16'h06C3, 16'h0766, 16'h083C};
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_word", word, 16'h0000);
    chk("rst_valid", 16'(word_valid), 16'h0);
    check_state("rst");
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    send_word(16'h0C01, "shutdown_on");
    for (int r = 0; r < 8; r++) send_word(rows_in[r], $sformatf("row_w%0d", r));
    send_word(16'h0F01, "test_on");
    send_word(16'h0F00, "test_off");
    send_word(16'h0B07, "scan7");
    send_word(16'h0900, "decode0");

    send_bits(32'h5A3, 12);
    latch_word("short12");
    send_bits(32'hC3, 8);
    send_bits(32'h0A05, 16);
    latch_word("over24");

    // Final bit's clock and latch rise together.
    send_bits(32'h0102 >> 1, 15);
    @(negedge clk) ser_data = 1'b0;
    repeat (PH) @(negedge clk);
    ser_clk = 1'b1;
    ser_latch = 1'b1;
    hist.push_back(1'b0);
    m_cnt++;
    commit_check("simul");
    repeat (PH) @(negedge clk);
    ser_clk = 1'b0;
    ser_latch = 1'b0;
    repeat (PH) @(negedge clk);
    check_state("simul");
    send_bits(32'hABC, 12);
    latch_word("after_simul");

    for (int k = 0; k < 8; k++) begin
      send_bits($urandom, int'($urandom_range(8, 24)));
      latch_word($sformatf("rand%0d", k));
    end

    send_word(16'h0C01, "pre_rst");
    send_bits(32'h0C01 >> 7, 9);
    @(negedge clk) reset_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_word", word, 16'h0000);
    chk("midrst_dout", 16'(dout), 16'h0);
    chk("midrst_shutdn", 16'(shutdown_n), 16'h0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check_state("midrst");
    send_word(16'h0A03, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/max7219_receiver.md
Name: max7219_receiver

Overview:
- Receive end of the 3-wire LED-matrix serial link (data, clock, latch) that our shift-out path drives.
- Samples the serial stream, assembles 16-bit register words MSB-first and commits each word on the latch rising edge.
- Decodes commits into an 8x8 row RAM and MAX7219-compatible control registers.
- Used as an on-chip display emulator and as a loopback checker for the transmit side.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on each serial input before edge detection (minimum 2).
- ROWS, 8, number of digit/row registers (addresses 1..ROWS).

Ports:
- clk_in  input  1  system clock
- reset_n_in  input  1  asynchronous active-low reset
- ser_clk_in  input  1  serial clock, asynchronous to clk_in
- ser_data_in  input  1  serial data, asynchronous
- ser_latch_in  input  1  load/latch, asynchronous
- row_addr_in  input  3  row RAM read address (0 = row 1)
- row_data_out  output  8  row RAM read data, registered
- decode_mode_out  output  8  register 0x9
- intensity_out  output  4  register 0xA, low nibble
- scan_limit_out  output  3  register 0xB, low 3 bits
- shutdown_n_out  output  1  register 0xC bit 0 (0 = shut down)
- display_test_out  output  1  register 0xF bit 0
- word_valid_out  output  1  one-cycle pulse per committed word
- word_out  output  16  last committed word, held
- short_frame_out  output  1  one-cycle pulse with word_valid_out when fewer than 16 bits preceded the latch
- dout_out  output  1  daisy-chain data out: bit shifted out of shift register MSB

Behaviour:
- Reset (async assert, sync release): every output, the row RAM, the shift register and the bit counter clear to 0. shutdown_n_out = 0, so the display powers up shut down.
- Synchronisation:
  - Each serial input passes through SYNC_STAGES flops, plus one extra flop for edge detection.
  - Edge events are single clk_in cycles.
  - Serial clock high and low phases must each be at least SYNC_STAGES+2 clk_in periods; shorter phases are unsupported.
- FSM states: IDLE, SHIFT, COMMIT.
  - IDLE -> SHIFT on the first ser_clk rising edge.
  - SHIFT stays in SHIFT on each rising edge. On each edge: shift_reg <= {shift_reg[14:0], data_sync}; bit_count saturates at 31.
  - SHIFT -> COMMIT on a latch rising edge.
  - IDLE + latch rising edge with bit_count 0: no commit, stay IDLE.
  - COMMIT lasts exactly 1 cycle, then goes to IDLE with bit_count cleared. The shift register is not cleared.
- Simultaneous ser_clk and latch rising edges in the same cycle: shift first, then commit the shifted value.
- COMMIT cycle:
  - Address = word[11:8]; bits [15:12] are ignored.
  - Address 0: no-op.
  - Addresses 1..ROWS: row RAM[addr-1] <= word[7:0].
  - 0x9: decode_mode_out. 0xA: intensity_out. 0xB: scan_limit_out. 0xC: shutdown_n_out. 0xF: display_test_out.
  - Other addresses: ignored.
  - word_out <= word. word_valid_out pulses in the cycle after COMMIT.
  - short_frame_out pulses with it if bit_count < 16.
  - More than 16 bits: only the last 16 count, with no error flag (overrun is legal, as with daisy-chaining).
- Latency: register outputs and row RAM update 1 clk_in cycle after the synchronised latch edge. Total from the raw latch pin is SYNC_STAGES+2 cycles.
- row_data_out: registered read, 1-cycle latency. A write and read to the same row in the same cycle returns the old data.
- dout_out = shift_reg[15]. It changes only on synchronised ser_clk rising edges.
- Reset asserted mid-word: shift state is discarded, all registers clear, FSM returns to IDLE.
- Latch held high: only the rising edge commits. Further clocks while latch is high keep shifting.

Test Plan:
- Send 0x0C01 MSB-first, then latch -> shutdown_n_out 0->1; word_valid_out single pulse; word_out = 0x0C01; short_frame_out = 0.
- Send the eight rows 0x013C, 0x027E, 0x0399, 0x04FF, 0x05FF, 0x06C3, 0x0766, 0x083C, each latched -> reading row_addr_in 0..7 returns 3C,7E,99,FF,FF,C3,66,3C one cycle after each address.
- Send 0x0F01 then 0x0F00 -> display_test_out goes 1, then 0. Send 0x0B07 -> scan_limit_out = 7. Send 0x0900 -> decode_mode_out = 0.
- Send 12 bits, then latch -> short_frame_out pulses with word_valid_out. Send 24 bits ending 0x0A05 -> intensity_out = 5, no short flag. dout_out replays the first 8 bits 16 clocks late.
- Drop reset_n_in after 9 bits of 0x0C01, release, send a full 0x0A03 -> all outputs clear on the reset; afterwards only intensity_out = 3 and shutdown_n_out stays 0.
- Raise ser_clk and latch in the same cycle on the 16th bit of 0x0102 -> row 1 = 0x02, bit_count returns to 0.
